// File: rtl/router_pkt_rx.sv
// Destination-side packet receiver: drains a router output FIFO, checks parity, streams payload.
// Optional macro RX_STATS_EN builds saturating good-packet / error-packet counters.
module router_pkt_rx #(
  parameter int TIMEOUT = 31,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rx_en,
  input  logic             empty,
  input  logic [7:0]       fifo_data,
  output logic             re,
  output logic             soft_reset,
  output logic             sop,
  output logic [5:0]       hdr_len,
  output logic [1:0]       hdr_addr,
  output logic [7:0]       data_out,
  output logic             data_valid,
  output logic             pkt_done,
  output logic             parity_err,
  output logic             timeout_err,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {HDR, PAY, PAR} state_t;

  // The abort fires on the edge that would take tcnt to TIMEOUT, so the pulses are registered.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_next;
  logic       byte_arr;
  logic [7:0] acc, acc_next;
  logic [7:0] tcnt, tcnt_next;
  logic [5:0] remaining, remaining_next;
  logic [5:0] hdr_len_next;
  logic [1:0] hdr_addr_next;
  logic [7:0] data_out_next;
  logic       sop_next, data_valid_next, pkt_done_next;
  logic       parity_err_next, timeout_err_next, soft_reset_next;

  assign re = rx_en && !empty && !reset && !soft_reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= HDR;
      byte_arr    <= 1'b0;
      acc         <= '0;
      tcnt        <= '0;
      remaining   <= '0;
      hdr_len     <= '0;
      hdr_addr    <= '0;
      data_out    <= '0;
      sop         <= 1'b0;
      data_valid  <= 1'b0;
      pkt_done    <= 1'b0;
      parity_err  <= 1'b0;
      timeout_err <= 1'b0;
      soft_reset  <= 1'b0;
    end else begin
      state       <= state_next;
      byte_arr    <= re;
      acc         <= acc_next;
      tcnt        <= tcnt_next;
      remaining   <= remaining_next;
      hdr_len     <= hdr_len_next;
      hdr_addr    <= hdr_addr_next;
      data_out    <= data_out_next;
      sop         <= sop_next;
      data_valid  <= data_valid_next;
      pkt_done    <= pkt_done_next;
      parity_err  <= parity_err_next;
      timeout_err <= timeout_err_next;
      soft_reset  <= soft_reset_next;
    end
  end

  always_comb begin
    state_next       = state;
    acc_next         = acc;
    tcnt_next        = tcnt;
    remaining_next   = remaining;
    hdr_len_next     = hdr_len;
    hdr_addr_next    = hdr_addr;
    data_out_next    = data_out;
    sop_next         = 1'b0;
    data_valid_next  = 1'b0;
    pkt_done_next    = 1'b0;
    parity_err_next  = 1'b0;
    timeout_err_next = 1'b0;
    soft_reset_next  = 1'b0;
    case (state)
      PAY, PAR: begin
        if (byte_arr) begin
          tcnt_next = '0;
          if (state == PAY) begin
            data_out_next   = fifo_data;
            data_valid_next = 1'b1;
            acc_next        = acc ^ fifo_data;
            remaining_next  = remaining - 6'd1;
            if (remaining == 6'd1) state_next = PAR;
          end else begin
            pkt_done_next   = 1'b1;
            parity_err_next = (acc != fifo_data);
            state_next      = HDR;
          end
        end else if (rx_en) begin
          // Stall counting only advances while the client is willing to read.
          if (tcnt == TMO_LAST) begin
            pkt_done_next    = 1'b1;
            timeout_err_next = 1'b1;
            soft_reset_next  = 1'b1;
            tcnt_next        = '0;
            state_next       = HDR;
          end else begin
            tcnt_next = tcnt + 8'd1;
          end
        end
      end
      default: begin
        tcnt_next = '0;
        if (byte_arr) begin
          hdr_len_next   = fifo_data[7:2];
          hdr_addr_next  = fifo_data[1:0];
          acc_next       = fifo_data;
          remaining_next = fifo_data[7:2];
          sop_next       = 1'b1;
          state_next     = (fifo_data[7:2] != 6'd0) ? PAY : PAR;
        end else begin
          state_next = HDR;
        end
      end
    endcase
  end

`ifdef RX_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      pkt_cnt <= '0;
      err_cnt <= '0;
    end else if (pkt_done) begin
      if (parity_err || timeout_err) begin
        if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
      end else if (pkt_cnt != '1) begin
        pkt_cnt <= pkt_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign pkt_cnt = '0;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_router_pkt_rx.sv
// Self-checking bench for router_pkt_rx: a queue-based FIFO model feeds packets and a
// scoreboard of expected headers, payload bytes and completion flags is checked per cycle.
module tb_router_pkt_rx;

  localparam int TIMEOUT = 31;
  localparam int CNT_W   = 16;

  logic             clock;
  logic             reset;
  logic             rx_en;
  logic             empty;
  logic [7:0]       fifo_data;
  logic             re;
  logic             soft_reset;
  logic             sop;
  logic [5:0]       hdr_len;
  logic [1:0]       hdr_addr;
  logic [7:0]       data_out;
  logic             data_valid;
  logic             pkt_done;
  logic             parity_err;
  logic             timeout_err;
  logic [CNT_W-1:0] pkt_cnt;
  logic [CNT_W-1:0] err_cnt;

  router_pkt_rx #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .rx_en(rx_en), .empty(empty), .fifo_data(fifo_data),
    .re(re), .soft_reset(soft_reset), .sop(sop), .hdr_len(hdr_len), .hdr_addr(hdr_addr),
    .data_out(data_out), .data_valid(data_valid), .pkt_done(pkt_done),
    .parity_err(parity_err), .timeout_err(timeout_err), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  // FIFO contents, bytes held back for later release, and scoreboard queues.
  logic [7:0] fifo_q[$];
  logic [7:0] pend_q[$];
  logic [7:0] exp_hdr[$];
  logic [7:0] exp_data[$];
  logic [1:0] exp_done[$];
  int         pop_cycles[$];

  int n_cmp = 0;
  int n_err = 0;
  int cycle = 0;
  int last_byte_cycle = 0;
  int exp_pkt = 0;
  int exp_err = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cycle);
    end
  endtask

  task automatic checkLatency(input string tag);
    checkOutput({tag, "_pending"}, 32'(pop_cycles.size() != 0), 32'd1);
    if (pop_cycles.size() != 0) checkOutput(tag, 32'(cycle - pop_cycles.pop_front()), 32'd2);
  endtask

  // Queue one packet: header plus the first n_now payload bytes go into the FIFO now; the rest
  // (and parity) wait in pend_q. A stalled packet never gets its tail and must time out.
  task automatic applyStimulus(input logic [7:0] hdr, input logic [7:0] base, input int n_now,
                               input logic corrupt, input logic stall);
    int len;
    logic [7:0] par;
    logic [7:0] b;
    len = int'(hdr[7:2]);
    par = hdr;
    fifo_q.push_back(hdr);
    exp_hdr.push_back(hdr);
    for (int i = 0; i < len; i++) begin
      b = base + 8'(i * 17);
      par ^= b;
      if (i < n_now) begin
        fifo_q.push_back(b);
        exp_data.push_back(b);
      end else if (!stall) begin
        pend_q.push_back(b);
        exp_data.push_back(b);
      end
    end
    if (stall) begin
      exp_done.push_back(2'b01);
    end else begin
      if (corrupt) par ^= 8'h01;
      if (n_now >= len) fifo_q.push_back(par);
      else pend_q.push_back(par);
      exp_done.push_back({corrupt, 1'b0});
    end
  endtask

  task automatic releasePending();
    while (pend_q.size() != 0) fifo_q.push_back(pend_q.pop_front());
  endtask

  // Per-cycle monitor, run at the falling edge where every registered output is stable.
  task automatic monitor();
    logic [7:0] e;
    logic [1:0] d;
    if (sop) begin
      checkOutput("sop_pending", 32'(exp_hdr.size() != 0), 32'd1);
      if (exp_hdr.size() != 0) begin
        e = exp_hdr.pop_front();
        checkOutput("hdr_len", 32'(hdr_len), 32'(e[7:2]));
        checkOutput("hdr_addr", 32'(hdr_addr), 32'(e[1:0]));
      end
      checkLatency("sop_latency");
      last_byte_cycle = cycle;
    end
    if (data_valid) begin
      checkOutput("data_pending", 32'(exp_data.size() != 0), 32'd1);
      if (exp_data.size() != 0) checkOutput("data_out", 32'(data_out), 32'(exp_data.pop_front()));
      checkOutput("dv_not_done", 32'(pkt_done), 32'd0);
      checkLatency("data_latency");
      last_byte_cycle = cycle;
    end
    if (parity_err || timeout_err) checkOutput("err_has_done", 32'(pkt_done), 32'd1);
    if (soft_reset) begin
      checkOutput("srst_gap", 32'(cycle - last_byte_cycle), 32'(TIMEOUT));
      checkOutput("srst_done", 32'(pkt_done), 32'd1);
      checkOutput("srst_no_re", 32'(re), 32'd0);
    end
    if (pkt_done) begin
      checkOutput("done_pending", 32'(exp_done.size() != 0), 32'd1);
      if (exp_done.size() != 0) begin
        d = exp_done.pop_front();
        checkOutput("parity_err", 32'(parity_err), 32'(d[1]));
        checkOutput("timeout_err", 32'(timeout_err), 32'(d[0]));
        if (d[0]) checkOutput("srst_with_timeout", 32'(soft_reset), 32'd1);
        else checkLatency("done_latency");
        if (d == 2'b00) exp_pkt++;
        else exp_err++;
      end
    end
  endtask

  // One clock cycle: present FIFO status, monitor, then model the FIFO's registered read.
  task automatic step();
    logic pop;
    logic srst;
    empty = (fifo_q.size() == 0);
    #1;
    monitor();
    pop  = re && !empty;
    srst = soft_reset;
    if (pop) pop_cycles.push_back(cycle);
    @(posedge clock);
    #1;
    if (pop) fifo_data = fifo_q.pop_front();
    if (srst) fifo_q.delete();
    empty = (fifo_q.size() == 0);
    cycle++;
    @(negedge clock);
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    while (exp_done.size() != 0 && n < budget) begin
      step();
      n++;
    end
    checkOutput("done_in_budget", 32'(exp_done.size()), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput(tag, 32'({soft_reset, sop, hdr_len, hdr_addr, data_out, data_valid,
                          pkt_done, parity_err, timeout_err}), 32'd0);
    checkOutput({tag, "_cnt"}, 32'({pkt_cnt, err_cnt}), 32'd0);
  endtask

  task automatic checkStats(input string tag);
`ifdef RX_STATS_EN
    checkOutput({tag, "_pkt_cnt"}, 32'(pkt_cnt), 32'(exp_pkt));
    checkOutput({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
`else
    checkOutput({tag, "_pkt_cnt_tied"}, 32'(pkt_cnt), 32'd0);
    checkOutput({tag, "_err_cnt_tied"}, 32'(err_cnt), 32'd0);
`endif
  endtask

  // Main sequence: each directed packet scenario in turn, then final drain and summary.
  initial begin
    reset     = 1'b1;
    rx_en     = 1'b1;
    empty     = 1'b1;
    fifo_data = 8'h00;
    @(negedge clock);

    applyStimulus(8'h0D, 8'h11, 3, 1'b0, 1'b0);
    empty = (fifo_q.size() == 0);
    #1;
    checkOutput("re_in_reset", 32'(re), 32'd0);
    runCycles(2);
    #1;
    checkResetOutputs("reset_outputs");
    reset = 1'b0;
    waitDone(40);
    checkOutput("hdr_len_hold", 32'(hdr_len), 32'd3);
    checkOutput("hdr_addr_hold", 32'(hdr_addr), 32'd1);

    $display("[TB] parity error packet");
    applyStimulus(8'h0D, 8'h11, 3, 1'b1, 1'b0);
    waitDone(40);
    runCycles(2);
    checkStats("after_parity");

    $display("[TB] zero-length packet");
    applyStimulus(8'h02, 8'h00, 0, 1'b0, 1'b0);
    waitDone(40);

    $display("[TB] stalled packet times out");
    applyStimulus(8'h10, 8'hA1, 2, 1'b0, 1'b1);
    waitDone(TIMEOUT + 20);
    applyStimulus(8'h09, 8'h55, 2, 1'b0, 1'b0);
    waitDone(40);

    $display("[TB] rx_en dropped mid-payload");
    applyStimulus(8'h17, 8'h10, 2, 1'b0, 1'b0);
    runCycles(20);
    rx_en = 1'b0;
    runCycles(10);
    releasePending();
    empty = (fifo_q.size() == 0);
    #1;
    checkOutput("re_while_disabled", 32'(re), 32'd0);
    runCycles(10);
    checkOutput("no_early_done", 32'(exp_done.size()), 32'd1);
    rx_en = 1'b1;
    waitDone(40);
    runCycles(2);
    checkStats("after_hold");

    $display("[TB] reset during payload");
    applyStimulus(8'h15, 8'h20, 5, 1'b0, 1'b0);
    runCycles(5);
    reset = 1'b1;
    step();
    fifo_q.delete();
    pend_q.delete();
    exp_hdr.delete();
    exp_data.delete();
    exp_done.delete();
    pop_cycles.delete();
    exp_pkt = 0;
    exp_err = 0;
    #1;
    checkResetOutputs("mid_pkt_reset");
    reset = 1'b0;
    runCycles(2);
    applyStimulus(8'h0E, 8'h40, 3, 1'b0, 1'b0);
    waitDone(40);
    runCycles(4);

    checkOutput("hdr_q_empty", 32'(exp_hdr.size()), 32'd0);
    checkOutput("data_q_empty", 32'(exp_data.size()), 32'd0);
    checkStats("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/router_pkt_rx.md
Name: router_pkt_rx

Overview:
- Destination-side packet receiver for one router output port; drains the port's output FIFO through its read/empty interface.
- Parses packets of the form header byte {len[7:2], addr[1:0]}, then len payload bytes, then one parity byte.
- Parity byte = XOR of header and all payload bytes. The block checks it and streams payload to the client.
- On a stalled packet it raises a timeout and pulses a soft reset to the FIFO.

Parameters:
- TIMEOUT, 31, cycles with no byte arriving mid-packet before abort (1..255).
- CNT_W, 16, width of statistics counters.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- rx_en  in  1  client permits reads.
- empty  in  1  FIFO empty.
- fifo_data  in  8  FIFO registered read data; valid the cycle after re && !empty.
- re  out  1  FIFO read enable.
- soft_reset  out  1  one-cycle FIFO flush pulse on timeout.
- sop  out  1  pulse: header accepted.
- hdr_len  out  6  length field of current packet.
- hdr_addr  out  2  address field of current packet.
- data_out  out  8  payload byte.
- data_valid  out  1  data_out qualifier.
- pkt_done  out  1  pulse: packet finished (normal or aborted).
- parity_err  out  1  pulse with pkt_done: parity mismatch.
- timeout_err  out  1  pulse with pkt_done: timeout abort.
- pkt_cnt  out  CNT_W  good packets (optional feature).
- err_cnt  out  CNT_W  parity or timeout errors (optional feature).

Behaviour:
- Reset values: all outputs 0; state HDR; parity accumulator 0; timeout counter 0.
- Reset asserted mid-packet discards the packet. No pkt_done is generated.
- re is combinational: re = rx_en && !empty && !reset && !soft_reset. Reads are issued back-to-back and across packet boundaries.
- byte_arr is the registered (re && !empty) from the previous cycle. fifo_data is sampled only when byte_arr = 1.
- Latency: re high in cycle N → byte sampled at end of N+1 → data_out/data_valid/sop visible in N+2.
- State HDR, on byte_arr:
  - Latch hdr_len = byte[7:2] and hdr_addr = byte[1:0]; acc = byte; pulse sop.
  - Load remaining = len.
  - Go to PAY if len != 0, else go to PAR.
- State PAY, on byte_arr:
  - data_out = byte, data_valid = 1, acc ^= byte, remaining--.
  - When remaining reaches 0, go to PAR.
- State PAR, on byte_arr:
  - pkt_done = 1; parity_err = (acc != byte); go to HDR.
  - Payload data_valid never coincides with pkt_done.
- Timeout, in PAY/PAR only:
  - tcnt increments each cycle with rx_en=1 and byte_arr=0; it holds while rx_en=0 and clears on byte_arr.
  - When tcnt == TIMEOUT: pkt_done=1, timeout_err=1, soft_reset=1 for one cycle, state → HDR, tcnt → 0.
  - re is suppressed in the soft_reset cycle.
- HDR never times out.
- The block never reads when empty=1. A byte already in flight when rx_en falls is still processed.
- hdr_len/hdr_addr hold until the next header.
- Single-cycle pulses: sop, pkt_done, parity_err, timeout_err, soft_reset.

Optional Feature:
- Macro: RX_STATS_EN.
- Defined:
  - pkt_cnt increments on pkt_done with no error.
  - err_cnt increments on pkt_done with parity_err or timeout_err.
  - Both saturate at all-ones and clear on reset.
- Undefined: pkt_cnt and err_cnt are tied to 0 and no counter logic is built.

Test Plan:
- FIFO preloaded 0x0D,0x11,0x22,0x33,0x0D, rx_en=1 → sop with hdr_len=3, hdr_addr=1; data_out 0x11,0x22,0x33 on consecutive cycles; pkt_done=1 with parity_err=0; first data_valid 2 cycles after first payload re.
- Same packet with parity byte 0x0C → pkt_done=1 and parity_err=1; with RX_STATS_EN, err_cnt=1 and pkt_cnt=0.
- Zero-length packet 0x02,0x02 → sop with hdr_len=0, hdr_addr=2; no data_valid; pkt_done with parity_err=0.
- Header 0x10 (len 4) then 2 bytes, then FIFO empty for TIMEOUT=31 cycles → pkt_done+timeout_err+soft_reset pulse on cycle 31; next header parsed normally.
- rx_en dropped for 10 cycles mid-payload → re=0, tcnt holds, no timeout; packet completes correctly after rx_en returns.
- Reset asserted during PAY → all outputs 0 the next cycle, no pkt_done; the following packet parses correctly.
